// File: rtl/pong_frame_renderer_pkg.sv
// Shared definitions for the pong frame renderer slice.
//   - Screen geometry of the 640x480 timing the sync generator produces.
//   - Ball FSM state type.
//   - Small helper used by the pixel pipe to test a coordinate against a span.
package pong_frame_renderer_pkg;

  localparam int COORD_W    = 10;   // width of hpos/vpos and object coordinates
  localparam int H_VIDEO_ON = 640;  // visible pixels per line
  localparam int V_VIDEO_ON = 480;  // visible lines per frame

  // First blanking line: objects update here so they never move mid-picture.
  localparam int FRAME_TICK_VPOS = V_VIDEO_ON;

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_MISS  = 2'd2
  } ball_state_e;

  // True when lo <= pos < lo+len. 11 bits so lo+len cannot wrap on screen.
  function automatic logic in_span(input logic [10:0] pos,
                                   input logic [10:0] lo,
                                   input logic [10:0] len);
    return (pos >= lo) && (pos < lo + len);
  endfunction

endpackage

// File: rtl/pong_frame_renderer_if.sv
// Video bus between the VGA sync generator side and the renderer.
//   master : drives hpos/vpos/video_on/hsync/vsync, receives pixel outputs
//   slave  : the renderer; consumes timing, produces red/green/blue and
//            pix_hsync/pix_vsync (sync realigned with the pixel data)
interface pong_frame_renderer_if;
  import pong_frame_renderer_pkg::*;

  logic [COORD_W-1:0] hpos;
  logic [COORD_W-1:0] vpos;
  logic               video_on;
  logic               hsync;
  logic               vsync;

  logic [3:0]         red;
  logic [3:0]         green;
  logic [3:0]         blue;
  logic               pix_hsync;
  logic               pix_vsync;

  modport master (
    output hpos, vpos, video_on, hsync, vsync,
    input  red, green, blue, pix_hsync, pix_vsync
  );

  modport slave (
    input  hpos, vpos, video_on, hsync, vsync,
    output red, green, blue, pix_hsync, pix_vsync
  );

endinterface

// File: rtl/pong_frame_renderer_paddle_ctrl.sv
// pong_paddle_ctrl: one paddle's vertical position.
//   i_pixel_clock  pixel clock
//   i_reset_n      asynchronous active-low reset, y returns to Y_RESET
//   i_tick         once-per-frame update strobe
//   i_up / i_dn    buttons; exactly one pressed moves the paddle
//   o_y            top edge of the paddle, saturating in [0, 480-PADDLE_H]
module pong_paddle_ctrl
  import pong_frame_renderer_pkg::*;
#(
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_SPEED = 4,
  parameter int Y_RESET      = 208
) (
  input  logic               i_pixel_clock,
  input  logic               i_reset_n,
  input  logic               i_tick,
  input  logic               i_up,
  input  logic               i_dn,
  output logic [COORD_W-1:0] o_y
);

  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_VIDEO_ON - PADDLE_H);
  localparam logic [COORD_W-1:0] STEP  = COORD_W'(PADDLE_SPEED);

  logic [COORD_W-1:0] y_reg;
  logic [COORD_W-1:0] y_next;

  // Both buttons together cancel out; compare before subtracting so the
  // unsigned position can never wrap below zero.
  always_comb begin
    y_next = y_reg;
    if (i_tick && (i_up != i_dn)) begin
      if (i_up) begin
        y_next = (y_reg < STEP) ? '0 : y_reg - STEP;
      end else begin
        y_next = (y_reg > Y_MAX - STEP) ? Y_MAX : y_reg + STEP;
      end
    end
  end

  always_ff @(posedge i_pixel_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      y_reg <= COORD_W'(Y_RESET);
    end else begin
      y_reg <= y_next;
    end
  end

  assign o_y = y_reg;

endmodule

// File: rtl/pong_frame_renderer.sv
// pong_frame_renderer: game objects and pixel colouring for a pong screen.
//   i_pixel_clock        pixel clock
//   i_reset_n            asynchronous active-low reset
//   vid (slave)          timing in from the sync generator, 4:4:4 RGB and
//                        realigned hsync/vsync out (1 cycle latency)
//   i_up_l/i_dn_l        left paddle buttons (synchronous, debounced)
//   i_up_r/i_dn_r        right paddle buttons (synchronous, debounced)
//   o_miss_l             1-cycle pulse: ball left the screen on the left
//   o_miss_r             1-cycle pulse: ball left the screen on the right
// Paddles and ball update only on frame_tick (first blanking line, hpos 0).
module pong_frame_renderer
  import pong_frame_renderer_pkg::*;
#(
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_X_L   = 16,
  parameter int PADDLE_X_R   = 616,
  parameter int BALL_SPEED   = 2,
  parameter int PADDLE_SPEED = 4,
  parameter int SERVE_FRAMES = 60
) (
  input  logic                        i_pixel_clock,
  input  logic                        i_reset_n,
  pong_frame_renderer_if.slave        vid,
  input  logic                        i_up_l,
  input  logic                        i_dn_l,
  input  logic                        i_up_r,
  input  logic                        i_dn_r,
  output logic                        o_miss_l,
  output logic                        o_miss_r
);

  localparam logic [COORD_W-1:0] BALL_X_CENTRE   = COORD_W'((H_VIDEO_ON - BALL_SIZE) / 2);
  localparam logic [COORD_W-1:0] BALL_Y_CENTRE   = COORD_W'((V_VIDEO_ON - BALL_SIZE) / 2);
  localparam int                 PADDLE_Y_CENTRE = (V_VIDEO_ON - PADDLE_H) / 2;

  localparam logic [COORD_W-1:0] BS10     = COORD_W'(BALL_SIZE);
  localparam logic [COORD_W-1:0] PH10     = COORD_W'(PADDLE_H);
  localparam logic [COORD_W-1:0] SPEED10  = COORD_W'(BALL_SPEED);
  localparam logic [COORD_W-1:0] Y_BOTTOM = COORD_W'(V_VIDEO_ON - BALL_SIZE - BALL_SPEED);
  localparam logic [10:0]        BS11     = 11'(BALL_SIZE);
  localparam logic [10:0]        PW11     = 11'(PADDLE_W);
  localparam logic [10:0]        PH11     = 11'(PADDLE_H);
  localparam logic signed [10:0] SPEED_S  = 11'(BALL_SPEED);
  localparam logic signed [10:0] X_MAX_S  = 11'(H_VIDEO_ON - BALL_SIZE);

  localparam int                 CNT_W      = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

  logic frame_tick;
  assign frame_tick = (vid.vpos == COORD_W'(FRAME_TICK_VPOS)) && (vid.hpos == '0);

  // ---------------------------------------------------------------- paddles
  // Index 0 is the left paddle, index 1 the right one.
  logic [COORD_W-1:0] paddle_y [2];
  logic [1:0]         up_btn;
  logic [1:0]         dn_btn;
  logic [1:0]         paddle_px;

  assign up_btn = {i_up_r, i_up_l};
  assign dn_btn = {i_dn_r, i_dn_l};

  for (genvar gi = 0; gi < 2; gi++) begin : gen_paddle
    localparam logic [10:0] PX = 11'((gi == 0) ? PADDLE_X_L : PADDLE_X_R);

    pong_paddle_ctrl #(
      .PADDLE_H     (PADDLE_H),
      .PADDLE_SPEED (PADDLE_SPEED),
      .Y_RESET      (PADDLE_Y_CENTRE)
    ) u_paddle (
      .i_pixel_clock (i_pixel_clock),
      .i_reset_n     (i_reset_n),
      .i_tick        (frame_tick),
      .i_up          (up_btn[gi]),
      .i_dn          (dn_btn[gi]),
      .o_y           (paddle_y[gi])
    );

    assign paddle_px[gi] = in_span({1'b0, vid.hpos}, PX, PW11) &&
                           in_span({1'b0, vid.vpos}, {1'b0, paddle_y[gi]}, PH11);
  end

  // ------------------------------------------------------------- ball state
  ball_state_e        state_reg,     state_next;
  logic [CNT_W-1:0]   serve_cnt_reg, serve_cnt_next;
  logic [COORD_W-1:0] ball_x_reg,    ball_x_next;
  logic [COORD_W-1:0] ball_y_reg,    ball_y_next;
  logic               ball_dx_reg,   ball_dx_next;   // 1 = moving right
  logic               ball_dy_reg,   ball_dy_next;   // 1 = moving down
  logic               miss_left_reg, miss_left_next; // which side the last miss was on

  // Reflection and step, all evaluated on the current position.
  logic [10:0]        bx;
  logic               overlap_l, overlap_r, hit_l, hit_r;
  logic               dx_step, dy_step;
  logic signed [10:0] next_x;
  logic [COORD_W-1:0] next_y;
  logic               miss_l_now, miss_r_now;

  assign bx        = {1'b0, ball_x_reg};
  assign overlap_l = (ball_y_reg + BS10 > paddle_y[0]) && (ball_y_reg < paddle_y[0] + PH10);
  assign overlap_r = (ball_y_reg + BS10 > paddle_y[1]) && (ball_y_reg < paddle_y[1] + PH10);
  assign hit_l     = !ball_dx_reg && (bx <= 11'(PADDLE_X_L + PADDLE_W)) &&
                     (bx + BS11 > 11'(PADDLE_X_L)) && overlap_l;
  assign hit_r     = ball_dx_reg && (bx + BS11 >= 11'(PADDLE_X_R)) &&
                     (bx < 11'(PADDLE_X_R + PADDLE_W)) && overlap_r;

  // hit_l needs dx=left and hit_r needs dx=right, so they never collide.
  assign dx_step = hit_l | (ball_dx_reg & ~hit_r);
  assign dy_step = (ball_y_reg <= SPEED10)  ? 1'b1 :
                   (ball_y_reg >= Y_BOTTOM) ? 1'b0 : ball_dy_reg;

  // Signed so a step past the left edge shows up as a negative position.
  assign next_x     = dx_step ? ($signed(bx) + SPEED_S) : ($signed(bx) - SPEED_S);
  assign next_y     = dy_step ? (ball_y_reg + SPEED10) : (ball_y_reg - SPEED10);
  assign miss_l_now = (next_x < 11'sd0);
  assign miss_r_now = (next_x > X_MAX_S);

  always_comb begin
    state_next     = state_reg;
    serve_cnt_next = serve_cnt_reg;
    ball_x_next    = ball_x_reg;
    ball_y_next    = ball_y_reg;
    ball_dx_next   = ball_dx_reg;
    ball_dy_next   = ball_dy_reg;
    miss_left_next = miss_left_reg;

    case (state_reg)
      ST_SERVE: begin
        ball_x_next = BALL_X_CENTRE;
        ball_y_next = BALL_Y_CENTRE;
        if (frame_tick) begin
          if (serve_cnt_reg == SERVE_LAST) begin
            state_next     = ST_PLAY;
            serve_cnt_next = '0;
          end else begin
            serve_cnt_next = serve_cnt_reg + 1'b1;
          end
        end
      end

      ST_PLAY: begin
        if (frame_tick) begin
          // A miss freezes the ball for this tick; the MISS cycle recentres it.
          if (miss_l_now || miss_r_now) begin
            state_next     = ST_MISS;
            miss_left_next = miss_l_now;
          end else begin
            ball_x_next  = next_x[COORD_W-1:0];
            ball_y_next  = next_y;
            ball_dx_next = dx_step;
            ball_dy_next = dy_step;
          end
        end
      end

      ST_MISS: begin
        // Serve toward the player who just missed.
        ball_x_next  = BALL_X_CENTRE;
        ball_y_next  = BALL_Y_CENTRE;
        ball_dx_next = !miss_left_reg;
        state_next   = ST_SERVE;
      end

      default: begin
        state_next = ST_SERVE;
      end
    endcase
  end

  always_ff @(posedge i_pixel_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg     <= ST_SERVE;
      serve_cnt_reg <= '0;
      ball_x_reg    <= BALL_X_CENTRE;
      ball_y_reg    <= BALL_Y_CENTRE;
      ball_dx_reg   <= 1'b1;
      ball_dy_reg   <= 1'b1;
      miss_left_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      serve_cnt_reg <= serve_cnt_next;
      ball_x_reg    <= ball_x_next;
      ball_y_reg    <= ball_y_next;
      ball_dx_reg   <= ball_dx_next;
      ball_dy_reg   <= ball_dy_next;
      miss_left_reg <= miss_left_next;
    end
  end

  assign o_miss_l = (state_reg == ST_MISS) &&  miss_left_reg;
  assign o_miss_r = (state_reg == ST_MISS) && !miss_left_reg;

  // ------------------------------------------------------------- pixel pipe
  logic ball_px;
  assign ball_px = in_span({1'b0, vid.hpos}, bx, BS11) &&
                   in_span({1'b0, vid.vpos}, {1'b0, ball_y_reg}, BS11);

  always_ff @(posedge i_pixel_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      vid.red       <= '0;
      vid.green     <= '0;
      vid.blue      <= '0;
      vid.pix_hsync <= 1'b0;
      vid.pix_vsync <= 1'b0;
    end else begin
      vid.pix_hsync <= vid.hsync;
      vid.pix_vsync <= vid.vsync;
      // Ball is tested first so it draws on top of a paddle.
      if (!vid.video_on) begin
        vid.red   <= '0;
        vid.green <= '0;
        vid.blue  <= '0;
      end else if (ball_px) begin
        vid.red   <= 4'h0;
        vid.green <= 4'hF;
        vid.blue  <= 4'h0;
      end else if (|paddle_px) begin
        vid.red   <= 4'hF;
        vid.green <= 4'hF;
        vid.blue  <= 4'hF;
      end else begin
        vid.red   <= '0;
        vid.green <= '0;
        vid.blue  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pong_frame_renderer.sv
// Self-checking bench for pong_frame_renderer. A behavioural game model
// predicts ball, paddles and miss pulses for each frame tick; predictions
// go through a scoreboard queue and are compared once the DUT has updated.
module tb_pong_frame_renderer;
  import pong_frame_renderer_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic up_l, dn_l, up_r, dn_r;
  logic miss_l, miss_r;

  always #5 clk = ~clk;

  pong_frame_renderer_if vid();

  pong_frame_renderer dut (
    .i_pixel_clock (clk),
    .i_reset_n     (rst_n),
    .vid           (vid.slave),
    .i_up_l        (up_l),
    .i_dn_l        (dn_l),
    .i_up_r        (up_r),
    .i_dn_r        (dn_r),
    .o_miss_l      (miss_l),
    .o_miss_r      (miss_r)
  );

  int error_count = 0;
  int check_count = 0;
  int tick_count  = 0;

  task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, actual, actual, expected, expected);
    end
  endtask

  // ----------------------------------------------------------- game model
  typedef struct {
    int x;
    int y;
    int pl;
    int pr;
    bit ml;
    bit mr;
  } exp_t;

  exp_t sb_q[$];

  int m_x, m_y, m_pl, m_pr, m_cnt;
  bit m_dx, m_dy, m_serve;

  task automatic model_reset();
    m_x = 316; m_y = 236; m_dx = 1'b1; m_dy = 1'b1;
    m_pl = 208; m_pr = 208; m_serve = 1'b1; m_cnt = 0;
  endtask

  function automatic int paddle_step(input int y, input bit u, input bit d);
    if (u && !d) return (y - 4 < 0) ? 0 : y - 4;
    if (d && !u) return (y + 4 > 416) ? 416 : y + 4;
    return y;
  endfunction

  task automatic model_tick(input bit ul, input bit dl, input bit ur, input bit dr, output exp_t e);
    int nx, ny;
    bit ndx, ndy, hl, hr;
    e.ml = 1'b0;
    e.mr = 1'b0;
    if (m_serve) begin
      if (m_cnt == 59) begin
        m_serve = 1'b0;
        m_cnt   = 0;
      end else begin
        m_cnt++;
      end
    end else begin
      ndy = m_dy;
      if (m_y <= 2) ndy = 1'b1;
      else if (m_y >= 470) ndy = 1'b0;
      hl = !m_dx && (m_x <= 24) && (m_x + 8 > 16) && (m_y + 8 > m_pl) && (m_y < m_pl + 64);
      hr =  m_dx && (m_x + 8 >= 616) && (m_x < 624) && (m_y + 8 > m_pr) && (m_y < m_pr + 64);
      ndx = m_dx;
      if (hl) ndx = 1'b1;
      if (hr) ndx = 1'b0;
      nx = ndx ? m_x + 2 : m_x - 2;
      ny = ndy ? m_y + 2 : m_y - 2;
      if (nx < 0) begin
        e.ml = 1'b1;
        m_x = 316; m_y = 236; m_dx = 1'b0; m_serve = 1'b1;
      end else if (nx > 632) begin
        e.mr = 1'b1;
        m_x = 316; m_y = 236; m_dx = 1'b1; m_serve = 1'b1;
      end else begin
        m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy;
      end
    end
    m_pl = paddle_step(m_pl, ul, dl);
    m_pr = paddle_step(m_pr, ur, dr);
    e.x  = m_x;
    e.y  = m_y;
    e.pl = m_pl;
    e.pr = m_pr;
  endtask

  // -------------------------------------------------------- bench helpers
  // Called at a falling edge; returns at a falling edge.
  task automatic do_tick(input bit ul, input bit dl, input bit ur, input bit dr);
    exp_t e;
    up_l = ul; dn_l = dl; up_r = ur; dn_r = dr;
    vid.vpos = 10'd480; vid.hpos = 10'd0; vid.video_on = 1'b0;
    model_tick(ul, dl, ur, dr, e);
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    vid.hpos = 10'd1;
    e = sb_q.pop_front();
    check_value("miss_l", {31'd0, miss_l}, {31'd0, e.ml});
    check_value("miss_r", {31'd0, miss_r}, {31'd0, e.mr});
    @(posedge clk);
    @(negedge clk);
    check_value("miss_l_width", {31'd0, miss_l}, 32'd0);
    check_value("miss_r_width", {31'd0, miss_r}, 32'd0);
    check_value("ball_x",   32'(dut.ball_x_reg),  32'(e.x));
    check_value("ball_y",   32'(dut.ball_y_reg),  32'(e.y));
    check_value("paddle_l", 32'(dut.paddle_y[0]), 32'(e.pl));
    check_value("paddle_r", 32'(dut.paddle_y[1]), 32'(e.pr));
    tick_count++;
    $display("tick %0d: ball=(%0d,%0d) paddles=%0d/%0d miss_l=%0b miss_r=%0b",
             tick_count, dut.ball_x_reg, dut.ball_y_reg, dut.paddle_y[0], dut.paddle_y[1],
             e.ml, e.mr);
  endtask

  task automatic pixel_probe(input string tag, input int h, input int v, input bit on,
                             input logic [11:0] rgb);
    vid.hpos = 10'(h); vid.vpos = 10'(v); vid.video_on = on;
    @(posedge clk);
    @(negedge clk);
    check_value(tag, {20'd0, vid.red, vid.green, vid.blue}, {20'd0, rgb});
    $display("pixel %s: h=%0d v=%0d rgb=%h", tag, h, v, {vid.red, vid.green, vid.blue});
  endtask

  task automatic track(input int pad, input int by, output bit u, output bit d);
    u = 1'b0;
    d = 1'b0;
    if (pad + 32 < by + 4 - 2) d = 1'b1;
    else if (pad + 32 > by + 4 + 2) u = 1'b1;
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    bit ul, dl, ur, dr;
    bit hs, vs;
    rst_n = 1'b0;
    up_l = 1'b0; dn_l = 1'b0; up_r = 1'b0; dn_r = 1'b0;
    vid.hpos = 10'd0; vid.vpos = 10'd0; vid.video_on = 1'b0;
    vid.hsync = 1'b1; vid.vsync = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_value("rst_rgb",    {20'd0, vid.red, vid.green, vid.blue}, 32'd0);
    check_value("rst_hsync",  {31'd0, vid.pix_hsync}, 32'd0);
    check_value("rst_vsync",  {31'd0, vid.pix_vsync}, 32'd0);
    check_value("rst_miss",   {30'd0, miss_l, miss_r}, 32'd0);
    vid.hsync = 1'b0; vid.vsync = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_value("rst_ball_x",   32'(dut.ball_x_reg),  32'd316);
    check_value("rst_ball_y",   32'(dut.ball_y_reg),  32'd236);
    check_value("rst_paddle_l", 32'(dut.paddle_y[0]), 32'd208);
    check_value("rst_paddle_r", 32'(dut.paddle_y[1]), 32'd208);

    // Pixel colouring and edges of each object.
    pixel_probe("px_paddle_l",    16, 208, 1'b1, 12'hFFF);
    pixel_probe("px_paddle_l_br", 23, 271, 1'b1, 12'hFFF);
    pixel_probe("px_below_pad",   23, 272, 1'b1, 12'h000);
    pixel_probe("px_paddle_r",   616, 240, 1'b1, 12'hFFF);
    pixel_probe("px_ball",       316, 236, 1'b1, 12'h0F0);
    pixel_probe("px_ball_br",    323, 243, 1'b1, 12'h0F0);
    pixel_probe("px_right_ball", 324, 243, 1'b1, 12'h000);
    pixel_probe("px_background", 100, 100, 1'b1, 12'h000);
    pixel_probe("px_blanking",   650, 208, 1'b0, 12'h000);
    pixel_probe("px_blank_pad",   16, 208, 1'b0, 12'h000);

    // Sync realignment: output equals input from the previous cycle.
    for (int i = 0; i < 16; i++) begin
      hs = 1'($urandom_range(0, 1));
      vs = 1'($urandom_range(0, 1));
      vid.hsync = hs; vid.vsync = vs;
      @(posedge clk);
      @(negedge clk);
      check_value("hsync_delay", {31'd0, vid.pix_hsync}, {31'd0, hs});
      check_value("vsync_delay", {31'd0, vid.pix_vsync}, {31'd0, vs});
    end

    // Reset during frame 3, mid-line, with paddles displaced.
    for (int i = 0; i < 3; i++) do_tick(1'b1, 1'b0, 1'b0, 1'b1);
    vid.hpos = 10'd16; vid.vpos = 10'(m_pl); vid.video_on = 1'b1;
    vid.hsync = 1'b1; vid.vsync = 1'b1;
    @(posedge clk);
    #1;
    check_value("pre_rst_rgb",   {20'd0, vid.red, vid.green, vid.blue}, 32'hFFF);
    check_value("pre_rst_hsync", {31'd0, vid.pix_hsync}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_value("async_rst_rgb",   {20'd0, vid.red, vid.green, vid.blue}, 32'd0);
    check_value("async_rst_hsync", {31'd0, vid.pix_hsync}, 32'd0);
    check_value("async_rst_vsync", {31'd0, vid.pix_vsync}, 32'd0);
    check_value("async_rst_miss",  {30'd0, miss_l, miss_r}, 32'd0);
    @(negedge clk);
    vid.hsync = 1'b0; vid.vsync = 1'b0; vid.video_on = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check_value("rerst_ball_x",   32'(dut.ball_x_reg),  32'd316);
    check_value("rerst_ball_y",   32'(dut.ball_y_reg),  32'd236);
    check_value("rerst_paddle_l", 32'(dut.paddle_y[0]), 32'd208);
    check_value("rerst_paddle_r", 32'(dut.paddle_y[1]), 32'd208);

    // Left paddle held up for 60 ticks: saturates at 0 without wrapping.
    for (int i = 0; i < 60; i++) do_tick(1'b1, 1'b0, 1'b0, 1'b0);
    check_value("paddle_l_sat", 32'(dut.paddle_y[0]), 32'd0);
    // Both buttons pressed: no movement.
    for (int i = 0; i < 5; i++) do_tick(1'b1, 1'b1, 1'b1, 1'b1);

    // Both paddles track the ball: rallies with wall and paddle bounces.
    for (int i = 0; i < 400; i++) begin
      track(m_pl, m_y, ul, dl);
      track(m_pr, m_y, ur, dr);
      do_tick(ul, dl, ur, dr);
    end
    // Left paddle parked at the top: left misses and serves follow.
    for (int i = 0; i < 600; i++) begin
      track(m_pr, m_y, ur, dr);
      do_tick(1'b1, 1'b0, ur, dr);
    end
    // Right paddle parked at the bottom: right misses.
    for (int i = 0; i < 600; i++) begin
      track(m_pl, m_y, ul, dl);
      do_tick(ul, dl, 1'b0, 1'b1);
    end
    // Random button mashing.
    for (int i = 0; i < 300; i++) begin
      do_tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
